// File: rtl/regfile_access_ctrl_if.sv
// Bundle of requester and register-file signals around regfile_access_ctrl.
// slave: the controller. master: requesters plus the register file itself.
interface regfile_access_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 5
) ();
  logic             rd_req;
  logic [DEPTH-1:0] rd_addr1;
  logic [DEPTH-1:0] rd_addr2;
  logic             rd_ack;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             wa_req;
  logic [DEPTH-1:0] wa_addr;
  logic [WIDTH-1:0] wa_data;
  logic             wa_ack;
  logic             wm_req;
  logic [DEPTH-1:0] wm_addr;
  logic [WIDTH-1:0] wm_data;
  logic             wm_ack;
  logic             rf_regwrite;
  logic [DEPTH-1:0] rf_rr1;
  logic [DEPTH-1:0] rf_rr2;
  logic [DEPTH-1:0] rf_wr;
  logic [WIDTH-1:0] rf_wd;
  logic [WIDTH-1:0] rf_rd1;
  logic [WIDTH-1:0] rf_rd2;

  modport slave (
    input  rd_req, rd_addr1, rd_addr2, wa_req, wa_addr, wa_data,
           wm_req, wm_addr, wm_data, rf_rd1, rf_rd2,
    output rd_ack, rd_data1, rd_data2, wa_ack, wm_ack,
           rf_regwrite, rf_rr1, rf_rr2, rf_wr, rf_wd
  );

  modport master (
    output rd_req, rd_addr1, rd_addr2, wa_req, wa_addr, wa_data,
           wm_req, wm_addr, wm_data, rf_rd1, rf_rd2,
    input  rd_ack, rd_data1, rd_data2, wa_ack, wm_ack,
           rf_regwrite, rf_rr1, rf_rr2, rf_wr, rf_wd
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Access scheduler for a 1W/2R register file: arbitrates ALU writeback (WA),
// load writeback (WM) and operand fetch (RD). Reads never share a cycle with
// a write, since the file's read ports float while RegWrite is high.
module regfile_access_ctrl #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEPTH         = 5,
  parameter int unsigned MAX_WR_STREAK = 4
) (
  input logic                clk,
  input logic                rst,
  regfile_access_ctrl_if.slave bus
);

  localparam int unsigned SW = $clog2(MAX_WR_STREAK + 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e           r_state, w_state_next;
  logic             r_wr_src;  // granted writer: 0 = WA, 1 = WM
  logic             r_rr_ptr;  // 0 favours WA on a tie
  logic [SW-1:0]    r_streak, w_streak_next;
  logic [DEPTH-1:0] r_rr1, r_rr2, r_wr;
  logic [WIDTH-1:0] r_wd, r_rd1, r_rd2;
  logic             r_rd_ack;

  logic w_wa_ack, w_wm_ack, w_wa_elig, w_wm_elig;
  logic w_wa_hit, w_wm_hit, w_rd_elig, w_grant_wm;

  // Eligibility: acked writers are masked so a held req is not granted twice;
  // a read waits behind any eligible write to one of its nonzero addresses.
  always_comb begin
    w_wa_ack  = (r_state == StWrite) && !r_wr_src;
    w_wm_ack  = (r_state == StWrite) && r_wr_src;
    w_wa_elig = bus.wa_req && !w_wa_ack;
    w_wm_elig = bus.wm_req && !w_wm_ack;
    w_wa_hit  = w_wa_elig && (bus.wa_addr != '0) &&
                ((bus.wa_addr == bus.rd_addr1) || (bus.wa_addr == bus.rd_addr2));
    w_wm_hit  = w_wm_elig && (bus.wm_addr != '0) &&
                ((bus.wm_addr == bus.rd_addr1) || (bus.wm_addr == bus.rd_addr2));
    w_rd_elig = bus.rd_req && (r_state != StRead) && !r_rd_ack && !w_wa_hit && !w_wm_hit;
  end

  // Arbitration: writes first (round-robin), unless a read has waited out the streak.
  always_comb begin
    w_state_next  = StIdle;
    w_grant_wm    = 1'b0;
    w_streak_next = r_streak;
    if (w_rd_elig && (r_streak == SW'(MAX_WR_STREAK))) begin
      w_state_next = StRead;
    end else if (w_wa_elig || w_wm_elig) begin
      w_state_next = StWrite;
      w_grant_wm   = w_wm_elig && (!w_wa_elig || r_rr_ptr);
    end else if (w_rd_elig) begin
      w_state_next = StRead;
    end
    if (!bus.rd_req || (w_state_next == StRead)) begin
      w_streak_next = '0;
    end else if ((w_state_next == StWrite) && w_rd_elig) begin
      w_streak_next = r_streak + SW'(1);
    end
  end

  // State, arbitration memory and latched file addresses/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_wr_src <= 1'b0;
      r_rr_ptr <= 1'b0;
      r_streak <= '0;
      r_wr     <= '0;
      r_wd     <= '0;
      r_rr1    <= '0;
      r_rr2    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_streak <= w_streak_next;
      if (w_state_next == StWrite) begin
        r_wr_src <= w_grant_wm;
        r_rr_ptr <= !w_grant_wm;
        r_wr     <= w_grant_wm ? bus.wm_addr : bus.wa_addr;
        r_wd     <= w_grant_wm ? bus.wm_data : bus.wa_data;
      end
      if (w_state_next == StRead) begin
        r_rr1 <= bus.rd_addr1;
        r_rr2 <= bus.rd_addr2;
      end
    end
  end

  // Capture file read data at the end of the READ cycle; ack it next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ack <= 1'b0;
      r_rd1    <= '0;
      r_rd2    <= '0;
    end else begin
      r_rd_ack <= (r_state == StRead);
      if (r_state == StRead) begin
        r_rd1 <= bus.rf_rd1;
        r_rd2 <= bus.rf_rd2;
      end
    end
  end

  // Outputs; a write to register 0 is acked but never reaches the file.
  always_comb begin
    bus.wa_ack      = w_wa_ack;
    bus.wm_ack      = w_wm_ack;
    bus.rd_ack      = r_rd_ack;
    bus.rd_data1    = r_rd1;
    bus.rd_data2    = r_rd2;
    bus.rf_regwrite = (r_state == StWrite) && (r_wr != '0);
    bus.rf_wr       = r_wr;
    bus.rf_wd       = r_wd;
    bus.rf_rr1      = r_rr1;
    bus.rf_rr2      = r_rr2;
  end

endmodule
